// File: rtl/param_lifo_fifo_queue.sv
// Bounded single-clock queue, LIFO (MODE=0) or FIFO (MODE=1), with sticky overflow/underflow flags.
// Optional high-water tracking output enabled by defining PLFQ_HIGH_WATER_EN.
module param_lifo_fifo_queue #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int MODE   = 0,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push_en,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop_en,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_data_valid,
   output logic [DATA_W-1:0] peek_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
`ifdef PLFQ_HIGH_WATER_EN
   ,
   output logic [CNT_W-1:0]  high_water
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [DATA_W-1:0] pop_data_r;
   logic              pop_valid_r;
   logic              overflow_r;
   logic              underflow_r;

   logic              pop_ok_s;
   logic              push_ok_s;
   logic [PTR_W-1:0]  top_idx_s;
   logic [PTR_W-1:0]  rd_idx_s;
   logic [PTR_W-1:0]  wr_idx_s;
   logic [CNT_W-1:0]  count_nxt_s;
   logic              is_empty_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Accept decisions, storage indices and next occupancy
   always_comb begin
      is_empty_s  = (count_r == {CNT_W{1'b0}});
      pop_ok_s    = pop_en && !is_empty_s;
      push_ok_s   = push_en && ((count_r != DEPTH_C) || pop_ok_s);
      top_idx_s   = PTR_W'(count_r - CNT_W'(1));
      if (MODE == 1) begin
         rd_idx_s = rd_ptr_r;
         wr_idx_s = wr_ptr_r;
      end else begin
         rd_idx_s = top_idx_s;
         // a simultaneous pop frees the top slot, so the push overwrites it
         wr_idx_s = pop_ok_s ? top_idx_s : PTR_W'(count_r);
      end
      if (push_ok_s && !pop_ok_s) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_ok_s && !push_ok_s) begin
         count_nxt_s = count_r - CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Control state: occupancy, pointers, popped data and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r     <= {CNT_W{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         pop_data_r  <= {DATA_W{1'b0}};
         pop_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (clear) begin
         count_r     <= {CNT_W{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         pop_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         count_r     <= count_nxt_s;
         pop_valid_r <= pop_ok_s;
         if (pop_ok_s) begin
            pop_data_r <= mem_r[rd_idx_s];
            rd_ptr_r   <= ptr_inc(rd_ptr_r);
         end
         if (push_ok_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (push_en && !push_ok_s) begin
            overflow_r <= 1'b1;
         end
         if (pop_en && !pop_ok_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (!reset && !clear && push_ok_s) begin
         mem_r[wr_idx_s] <= push_data;
      end
   end

`ifdef PLFQ_HIGH_WATER_EN
   logic [CNT_W-1:0] high_water_r;

   // Peak occupancy since the last reset or clear
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         high_water_r <= {CNT_W{1'b0}};
      end else if (count_nxt_s > high_water_r) begin
         high_water_r <= count_nxt_s;
      end
   end

   assign high_water = high_water_r;
`endif

   // stale storage stays hidden while empty
   assign peek_data      = is_empty_s ? {DATA_W{1'b0}} : mem_r[rd_idx_s];
   assign pop_data       = pop_data_r;
   assign pop_data_valid = pop_valid_r;
   assign count          = count_r;
   assign full           = (count_r == DEPTH_C);
   assign empty          = is_empty_s;
   assign overflow       = overflow_r;
   assign underflow      = underflow_r;

endmodule

// File: tb/tb_param_lifo_fifo_queue.sv
// Directed bench: one LIFO and one FIFO instance (DEPTH=4) driven by the same stimulus.
// Covers ordering, full/overflow, empty/underflow, push+pop corner cases, clear, reset and pointer wrap.
module tb_param_lifo_fifo_queue;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       push_en;
   logic [7:0] push_data;
   logic       pop_en;

   logic [7:0] l_pop_data, f_pop_data, l_peek, f_peek;
   logic       l_valid, f_valid, l_full, f_full, l_empty, f_empty;
   logic       l_ovf, f_ovf, l_udf, f_udf;
   logic [2:0] l_count, f_count;
`ifdef PLFQ_HIGH_WATER_EN
   logic [2:0] l_hw, f_hw;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   param_lifo_fifo_queue #(.DATA_W(8), .DEPTH(4), .MODE(0)) u_lifo (
      .clk(clk), .reset(reset), .clear(clear),
      .push_en(push_en), .push_data(push_data), .pop_en(pop_en),
      .pop_data(l_pop_data), .pop_data_valid(l_valid), .peek_data(l_peek),
      .full(l_full), .empty(l_empty), .count(l_count),
      .overflow(l_ovf), .underflow(l_udf)
`ifdef PLFQ_HIGH_WATER_EN
      , .high_water(l_hw)
`endif
   );

   param_lifo_fifo_queue #(.DATA_W(8), .DEPTH(4), .MODE(1)) u_fifo (
      .clk(clk), .reset(reset), .clear(clear),
      .push_en(push_en), .push_data(push_data), .pop_en(pop_en),
      .pop_data(f_pop_data), .pop_data_valid(f_valid), .peek_data(f_peek),
      .full(f_full), .empty(f_empty), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf)
`ifdef PLFQ_HIGH_WATER_EN
      , .high_water(f_hw)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [7:0] d);
      push_en   = 1'b1;
      push_data = d;
      tick();
      push_en   = 1'b0;
   endtask

   task automatic do_pop(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_f);
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      check_value({tag, "_l_data"}, 32'(l_pop_data), 32'(exp_l));
      check_value({tag, "_f_data"}, 32'(f_pop_data), 32'(exp_f));
      check_value({tag, "_l_valid"}, 32'(l_valid), 32'd1);
      check_value({tag, "_f_valid"}, 32'(f_valid), 32'd1);
   endtask

   task automatic check_both(input string tag, input logic [31:0] gl, input logic [31:0] gf,
                             input logic [31:0] el, input logic [31:0] ef);
      check_value({tag, "_l"}, gl, el);
      check_value({tag, "_f"}, gf, ef);
   endtask

   task automatic check_idle_state(input string tag);
      check_both({tag, "_count"}, 32'(l_count), 32'(f_count), 32'd0, 32'd0);
      check_both({tag, "_empty"}, 32'(l_empty), 32'(f_empty), 32'd1, 32'd1);
      check_both({tag, "_full"},  32'(l_full),  32'(f_full),  32'd0, 32'd0);
      check_both({tag, "_ovf"},   32'(l_ovf),   32'(f_ovf),   32'd0, 32'd0);
      check_both({tag, "_udf"},   32'(l_udf),   32'(f_udf),   32'd0, 32'd0);
      check_both({tag, "_valid"}, 32'(l_valid), 32'(f_valid), 32'd0, 32'd0);
      check_both({tag, "_peek"},  32'(l_peek),  32'(f_peek),  32'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; push_en = 1'b0; push_data = 8'h00; pop_en = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // reset state
      check_idle_state("rst");
      check_both("rst_pdata", 32'(l_pop_data), 32'(f_pop_data), 32'd0, 32'd0);

      // pop while empty
      pop_en = 1'b1; tick(); pop_en = 1'b0;
      check_both("epop_udf",   32'(l_udf),   32'(f_udf),   32'd1, 32'd1);
      check_both("epop_valid", 32'(l_valid), 32'(f_valid), 32'd0, 32'd0);
      check_both("epop_count", 32'(l_count), 32'(f_count), 32'd0, 32'd0);
      check_both("epop_peek",  32'(l_peek),  32'(f_peek),  32'd0, 32'd0);
      reset = 1'b1; tick(); reset = 1'b0;

      // ordering: LIFO reverses, FIFO preserves
      do_push(8'h11); do_push(8'h22); do_push(8'h33);
      check_both("ord_count", 32'(l_count), 32'(f_count), 32'd3, 32'd3);
      check_both("ord_peek",  32'(l_peek),  32'(f_peek),  32'h33, 32'h11);
      do_pop("ord_p1", 8'h33, 8'h11);
      check_both("ord_cnt2", 32'(l_count), 32'(f_count), 32'd2, 32'd2);
      do_pop("ord_p2", 8'h22, 8'h22);
      do_pop("ord_p3", 8'h11, 8'h33);
      tick();
      check_both("ord_vdrop", 32'(l_valid), 32'(f_valid), 32'd0, 32'd0);
      check_both("ord_empty", 32'(l_empty), 32'(f_empty), 32'd1, 32'd1);
      check_both("ord_cnt0",  32'(l_count), 32'(f_count), 32'd0, 32'd0);

      // fill to full, then one rejected push
      do_push(8'hA0); do_push(8'hA1); do_push(8'hA2); do_push(8'hA3);
      check_both("full_flag", 32'(l_full), 32'(f_full), 32'd1, 32'd1);
      check_both("full_ovf0", 32'(l_ovf),  32'(f_ovf),  32'd0, 32'd0);
      do_push(8'hA4);
      check_both("full_ovf1",  32'(l_ovf),   32'(f_ovf),   32'd1, 32'd1);
      check_both("full_count", 32'(l_count), 32'(f_count), 32'd4, 32'd4);
      tick();
      check_both("full_ovf_sticky", 32'(l_ovf), 32'(f_ovf), 32'd1, 32'd1);
      check_both("full_peek", 32'(l_peek), 32'(f_peek), 32'hA3, 32'hA0);

      // simultaneous push+pop while full
      push_en = 1'b1; push_data = 8'h55; pop_en = 1'b1;
      tick();
      push_en = 1'b0; pop_en = 1'b0;
      check_both("pp_data",  32'(l_pop_data), 32'(f_pop_data), 32'hA3, 32'hA0);
      check_both("pp_valid", 32'(l_valid), 32'(f_valid), 32'd1, 32'd1);
      check_both("pp_count", 32'(l_count), 32'(f_count), 32'd4, 32'd4);
      check_both("pp_peek",  32'(l_peek),  32'(f_peek),  32'h55, 32'hA1);
      check_both("pp_ovf",   32'(l_ovf),   32'(f_ovf),   32'd1, 32'd1);

      // drop to three entries, then clear
      do_pop("pre_clr", 8'h55, 8'hA1);
      check_both("pre_clr_count", 32'(l_count), 32'(f_count), 32'd3, 32'd3);
      clear = 1'b1; tick(); clear = 1'b0;
      check_idle_state("clr");
      check_both("clr_pdata_hold", 32'(l_pop_data), 32'(f_pop_data), 32'h55, 32'hA1);

      // reset mid-operation with count=3 and underflow set
      pop_en = 1'b1; tick(); pop_en = 1'b0;
      check_both("mr_udf", 32'(l_udf), 32'(f_udf), 32'd1, 32'd1);
      do_push(8'hC0); do_push(8'hC1); do_push(8'hC2);
      check_both("mr_count", 32'(l_count), 32'(f_count), 32'd3, 32'd3);
`ifdef PLFQ_HIGH_WATER_EN
      check_both("mr_hw3", 32'(l_hw), 32'(f_hw), 32'd3, 32'd3);
`endif
      reset = 1'b1; tick(); reset = 1'b0;
      check_idle_state("mr");
      check_both("mr_pdata", 32'(l_pop_data), 32'(f_pop_data), 32'd0, 32'd0);
`ifdef PLFQ_HIGH_WATER_EN
      check_both("mr_hw0", 32'(l_hw), 32'(f_hw), 32'd0, 32'd0);
`endif

      // push+pop on empty: pop rejected, push accepted
      push_en = 1'b1; push_data = 8'hD0; pop_en = 1'b1;
      tick();
      push_en = 1'b0; pop_en = 1'b0;
      check_both("ep_count", 32'(l_count), 32'(f_count), 32'd1, 32'd1);
      check_both("ep_udf",   32'(l_udf),   32'(f_udf),   32'd1, 32'd1);
      check_both("ep_valid", 32'(l_valid), 32'(f_valid), 32'd0, 32'd0);
      check_both("ep_peek",  32'(l_peek),  32'(f_peek),  32'hD0, 32'hD0);
      do_pop("ep_pop", 8'hD0, 8'hD0);

      // pointer wrap with interleaved traffic
      do_push(8'hB0); do_push(8'hB1); do_push(8'hB2);
      do_pop("wr_p0", 8'hB2, 8'hB0);
      do_push(8'hB3); do_push(8'hB4);
      check_both("wr_full", 32'(l_full), 32'(f_full), 32'd1, 32'd1);
      do_pop("wr_p1", 8'hB4, 8'hB1);
      do_pop("wr_p2", 8'hB3, 8'hB2);
      do_pop("wr_p3", 8'hB1, 8'hB3);
      do_pop("wr_p4", 8'hB0, 8'hB4);
      check_both("wr_empty", 32'(l_empty), 32'(f_empty), 32'd1, 32'd1);
      check_both("wr_udf",   32'(l_udf),   32'(f_udf),   32'd1, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/param_lifo_fifo_queue.md
Name: param_lifo_fifo_queue

Overview:
Parametrised synthesizable single-clock queue for testbench-adjacent and datapath buffering. It supersedes the fixed 8-bit, unbounded, LIFO-only queue.
- Adds configurable width, bounded depth and a LIFO/FIFO mode.
- Adds explicit push/pop enables with full/empty, occupancy count, sticky overflow/underflow flags and a synchronous flush.
- Sits between a producer and consumer; every output is visible to SVA checkers.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 16, storage entries (>=2, any integer; pointers wrap at DEPTH-1 -> 0)
MODE, 0, 0 = LIFO (stack), 1 = FIFO
CNT_W (localparam), $clog2(DEPTH+1), width of count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous flush
push_en  input  1  push request
push_data  input  DATA_W  data to push
pop_en  input  1  pop request
pop_data  output  DATA_W  last popped value, registered
pop_data_valid  output  1  one-cycle pulse, cycle after accepted pop
peek_data  output  DATA_W  next element to be popped, combinational; 0 when empty
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CNT_W  current occupancy
overflow  output  1  sticky: push rejected
underflow  output  1  sticky: pop rejected

Behaviour:
- Interface: one clock; reset is synchronous and active-high (port names clk, reset).
- Reset values: pop_data=0, pop_data_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0, pointers=0. Storage array is not reset.
- Reset has priority over clear. Clear has priority over push/pop.
- Clear zeroes count, pointers, overflow and underflow, and drives pop_data_valid=0. pop_data holds its value.
- Pop accepted: pop_en && !empty. Rejected pop sets underflow; count unchanged.
- Push accepted: push_en && (!full || pop accepted same cycle). Rejected push sets overflow; data dropped.
- LIFO:
  - Push writes at index count; pop reads index count-1.
  - Simultaneous accepted push+pop: pop returns the current top, push_data overwrites the top slot, count unchanged.
  - Legal when full.
- FIFO:
  - Push writes at wr_ptr; pop reads at rd_ptr; both wrap modulo DEPTH.
  - Simultaneous accepted push+pop: count unchanged. Legal when full.
- Push+pop when empty: pop rejected (underflow=1), push accepted, count becomes 1.
- Pop latency: pop_data updates and pop_data_valid pulses exactly 1 cycle after the accepting edge.
- count changes by +1, -1 or 0 per cycle. full and empty are derived from the registered count and valid the same cycle.
- peek_data: LIFO -> mem[count-1]; FIFO -> mem[rd_ptr]. Reflects a push on the cycle after the push.
- Reset mid-operation: queue is logically empty on the next cycle; stale storage is never observable via peek_data (0 when empty).

Optional Feature:
Macro PLFQ_HIGH_WATER_EN.
- Defined: adds output high_water [CNT_W] = maximum count since reset/clear. Updated the cycle count rises above it; reset/clear -> 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- LIFO, DEPTH=4: push 0x11,0x22,0x33, then pop x3 -> pop_data 0x33,0x22,0x11, each with a one-cycle pop_data_valid; count 3->0; empty=1 at end.
- FIFO, DEPTH=4: same stimulus -> 0x11,0x22,0x33. Then push 5 more and pop 4 to exercise pointer wrap -> strict order preserved.
- Full: push 0xA0..0xA4 into DEPTH=4 -> full=1 after 4th push, 0xA4 dropped, overflow=1 and stays 1, count=4.
- Empty pop: pop_en for 1 cycle at reset state -> underflow=1, pop_data_valid=0, count=0, peek_data=0.
- Full + simultaneous push 0x55 and pop:
  - LIFO -> pop_data=old top, peek_data=0x55, count=4.
  - FIFO -> pop_data=old head, count=4, overflow unchanged.
- Assert reset (then clear, separately) with count=3 -> next cycle count=0, empty=1, flags=0. With PLFQ_HIGH_WATER_EN, high_water=0 after, and =3 before.
